sram_burst_master: RTL and testbench
====================================

Name: sram_burst_master

Overview:
Initiator-side controller for the on-chip 8-bit byte SRAM. It accepts burst read/write commands from a host over valid/ready channels and streams write data in and read data out. It drives the SRAM port (address, write data, write enable) and captures its read data. It sits between host logic (UART bridge, test sequencer) and the SRAM instance.

Parameters:
ADDR_W, 8, SRAM address width; memory depth is 2^ADDR_W.
DATA_W, 8, SRAM data width.

Ports:
clk  input  1  system clock; all block state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
cmd_valid  input  1  host command valid.
cmd_ready  output  1  block can accept a command (high only in IDLE).
cmd_write  input  1  1 = burst write, 0 = burst read.
cmd_addr  input  ADDR_W  burst start address.
cmd_len  input  ADDR_W  beats minus 1 (0 means 1 beat, 255 means 256 beats).
wr_valid  input  1  write beat valid.
wr_ready  output  1  block accepts a write beat.
wr_data  input  DATA_W  write beat data.
rd_valid  output  1  read beat valid.
rd_ready  input  1  host accepts a read beat.
rd_data  output  DATA_W  read beat data.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a burst completes.
mem_addr  output  ADDR_W  SRAM address, registered.
mem_wdata  output  DATA_W  SRAM write data, registered.
mem_we  output  1  SRAM write enable, registered.
mem_rdata  input  DATA_W  SRAM read data.

Behaviour:
- SRAM contract: the SRAM samples mem_addr, mem_wdata and mem_we on the falling edge of clk. With mem_we=0, it presents memory[mem_addr] on mem_rdata before the next rising edge.
- Reset values (asynchronous): state=IDLE, cmd_ready=1 once reset is released, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0, mem_addr=0, mem_wdata=0, mem_we=0, internal beat counter=0.
- States: IDLE, WRITE, RD_ISSUE, RD_HOLD, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr=cmd_addr and cnt=cmd_len, and set mem_addr=cmd_addr.
  - Next state is WRITE if cmd_write=1, otherwise RD_ISSUE.
- WRITE:
  - wr_ready=1.
  - Each rising edge with wr_valid&&wr_ready registers mem_we=1, mem_addr=addr, mem_wdata=wr_data; the write lands on the following falling edge.
  - On a cycle with no accepted beat, mem_we returns to 0.
  - After each beat, addr increments modulo 2^ADDR_W (0xFF wraps to 0x00).
  - On acceptance of the last beat (cnt==0), go to DONE.
- RD_ISSUE:
  - mem_we=0 and mem_addr=addr.
  - Next rising edge: rd_data<=mem_rdata, rd_valid<=1, go to RD_HOLD.
- RD_HOLD:
  - rd_data and rd_valid are held stable until rd_ready.
  - On rd_valid&&rd_ready: rd_valid<=0.
  - If cnt==0, go to DONE. Otherwise decrement cnt, increment addr (with wrap), set mem_addr to the new addr, and go to RD_ISSUE.
  - Read throughput is 1 beat per 2 cycles when rd_ready is held high.
- DONE: done=1 for exactly one cycle, mem_we=0, then go to IDLE.
- Channel gating: wr_ready is 0 outside WRITE; rd_valid is 0 outside RD_HOLD. cmd_valid is ignored while busy.
- Write latency: mem_we rises at the edge after the beat is accepted.
- Read latency: rd_valid rises 2 cycles after command acceptance.
- Reset mid-burst: immediate abort. mem_we=0 asynchronously; any write beat not yet sampled by the SRAM is lost; no done pulse is generated.
- Simultaneous wr_valid in IDLE/DONE: no effect; the beat is not consumed.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release reset -> cmd_ready=1, busy=0.
- Single write then read: write addr 0x10, len 0, data 0xA5 -> one mem_we pulse with mem_addr=0x10 and mem_wdata=0xA5, then done. A read of 0x10 returns rd_data=0xA5 with rd_valid 2 cycles after cmd accept, then done.
- Wrap burst: write addr 0xFE, len 3, data 0x11/0x22/0x33/0x44 -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01. Readback of the same burst returns 0x11, 0x22, 0x33, 0x44 in order.
- Backpressure and gaps:
  - Drop wr_valid for 3 cycles mid-burst -> mem_we=0 during the gap and no address skip.
  - Hold rd_ready=0 for 5 cycles -> rd_data is stable and mem_addr does not advance.
- Reset mid-operation: assert reset during beat 2 of a 4-beat write -> mem_we drops immediately and no done pulse. After release, cmd_ready=1 and a read of beat 3's address shows its old value.
- Full sweep: write len 255 from addr 0x80 with data=addr, then read it all back -> 256 beats match, exactly one done pulse each.

Source files
------------

// File: rtl/sram_burst_master.sv
// Burst read/write initiator for the byte-wide on-chip SRAM. The SRAM samples the
// registered port on the falling edge, so each write lands half a cycle after it is registered.
//   state    | meaning
//   IDLE     | waiting for a host command
//   WRITE    | accepting write beats, one SRAM write per accepted beat
//   RD_ISSUE | read address on the SRAM port, data captured at the next edge
//   RD_HOLD  | read beat presented until the host takes it
//   DONE     | one-cycle completion pulse
module sram_burst_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_HOLD, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              mem_we_q;
  logic              rd_valid_q;
  logic [ADDR_W-1:0] addr_d;

  // Natural overflow gives the wrap from the top address back to zero.
  assign addr_d = addr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          if (cmd_valid) begin
            addr_q     <= cmd_addr;
            cnt_q      <= cmd_len;
            mem_addr_q <= cmd_addr;
            state_q    <= cmd_write ? WRITE : RD_ISSUE;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= wr_data;
            addr_q      <= addr_d;
            if (cnt_q == '0) state_q <= DONE;
            else             cnt_q   <= cnt_q - ADDR_W'(1);
          end else begin
            mem_we_q <= 1'b0;
          end
        end
        RD_ISSUE: begin
          mem_we_q   <= 1'b0;
          rd_data_q  <= mem_rdata;
          rd_valid_q <= 1'b1;
          state_q    <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rd_valid_q && rd_ready) begin
            rd_valid_q <= 1'b0;
            if (cnt_q == '0) begin
              state_q <= DONE;
            end else begin
              cnt_q      <= cnt_q - ADDR_W'(1);
              addr_q     <= addr_d;
              mem_addr_q <= addr_d;
              state_q    <= RD_ISSUE;
            end
          end
        end
        DONE: begin
          // Last write beat (if any) has landed on the falling edge of this cycle.
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = reset && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_ready  = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_sram_burst_master.sv
// Scoreboard bench for sram_burst_master: a falling-edge SRAM model, a byte-array reference
// memory, and monitors that pop expected write/read beats as the DUT presents them.
module tb_sram_burst_master;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          cmd_ready, wr_ready, rd_valid, busy, done, mem_we;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  sram_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram    [256];
  logic [DW-1:0] ref_mem [256];
  logic [15:0]   exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: samples the port on the falling edge
  always @(negedge clk) begin
    if (mem_we) sram[mem_addr] = mem_wdata;
    else        mem_rdata = sram[mem_addr];
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    logic [15:0]   ew;
    logic [DW-1:0] er;
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h with no write expected", mem_addr, mem_wdata);
      end else begin
        ew = exp_wr.pop_front();
        chk("wr_beat", {mem_addr, mem_wdata}, ew);
      end
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_unexpected: got 0x%0h with no read expected", rd_data);
      end else begin
        er = exp_rd.pop_front();
        chk("rd_beat", rd_data, er);
      end
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin tick(); t++; end
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] l);
    int t = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && t < 200) begin tick(); t++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
  endtask

  task automatic write_burst(input logic [7:0] a, input int n, input logic [7:0] d[$],
                             input int gap_at, input int gap_n);
    int d0 = done_cnt;
    send_cmd(1'b1, a, 8'(n - 1));
    for (int i = 0; i < n; i++) begin
      int g;
      g = (i == gap_at) ? gap_n : int'($urandom_range(0, 1));
      wr_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        tick();
        if (i == gap_at) chk("gap_we_low", mem_we, 1'b0);
      end
      wr_valid = 1'b1;
      wr_data  = d[i];
      chk("wr_ready", wr_ready, 1'b1);
      exp_wr.push_back({8'(a + i), d[i]});
      ref_mem[8'(a + i)] = d[i];
      tick();
    end
    wr_valid = 1'b0;
    wr_data  = 8'($urandom);
    wait_idle();
    chk("wr_done_pulses", done_cnt - d0, 1);
  endtask

  task automatic read_burst(input logic [7:0] a, input int n, input int hold_at);
    int d0 = done_cnt;
    for (int i = 0; i < n; i++) exp_rd.push_back(ref_mem[8'(a + i)]);
    send_cmd(1'b0, a, 8'(n - 1));
    chk("rd_lat_issue", rd_valid, 1'b0);
    tick();
    chk("rd_lat_valid", rd_valid, 1'b1);
    for (int i = 0; i < n; i++) begin
      int t, g;
      logic [7:0] hd, ha;
      t = 0;
      while (!rd_valid && t < 50) begin tick(); t++; end
      chk("rd_valid_wait", rd_valid, 1'b1);
      g  = (i == hold_at) ? 5 : int'($urandom_range(0, 2));
      hd = rd_data;
      ha = mem_addr;
      if (i == hold_at) chk("rd_hold_addr_beat", mem_addr, 8'(a + i));
      for (int k = 0; k < g; k++) begin
        tick();
        if (i == hold_at) begin
          chk("rd_hold_valid", rd_valid, 1'b1);
          chk("rd_hold_data", rd_data, hd);
          chk("rd_hold_addr", mem_addr, ha);
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    wait_idle();
    chk("rd_done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    logic [7:0] a;
    int n, d0;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 8'($urandom);
      ref_mem[i] = sram[i];
    end

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
      cmd_addr = 8'($urandom); cmd_len = 8'($urandom);
      wr_valid = 1'($urandom); wr_data = 8'($urandom); rd_ready = 1'($urandom);
      tick();
    end
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_mem_we", mem_we, 1'b0);
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);
    tick();

    // Single write then read
    d = {8'hA5};
    write_burst(8'h10, 1, d, -1, 0);
    read_burst(8'h10, 1, -1);

    // Wrap burst
    d = {8'h11, 8'h22, 8'h33, 8'h44};
    write_burst(8'hFE, 4, d, -1, 0);
    read_burst(8'hFE, 4, -1);

    // Write gap and read backpressure
    d = {8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
    write_burst(8'h30, 5, d, 2, 3);
    read_burst(8'h30, 5, 2);

    // Reset during beat 2 of a 4-beat write
    a = 8'h40;
    send_cmd(1'b1, a, 8'd3);
    d0 = done_cnt;
    wr_valid = 1'b1;
    wr_data  = ~ref_mem[a];
    exp_wr.push_back({a, wr_data});
    ref_mem[a] = wr_data;
    tick();
    wr_data = ~ref_mem[8'(a + 1)];
    tick();
    reset = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (3) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    reset = 1'b1;
    #1;
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    tick();
    read_burst(a, 4, -1);

    // Random bursts
    for (int r = 0; r < 6; r++) begin
      a = 8'($urandom);
      n = int'($urandom_range(1, 16));
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      write_burst(a, n, d, int'($urandom_range(0, n - 1)), int'($urandom_range(1, 4)));
      read_burst(a, n, int'($urandom_range(0, n - 1)));
    end

    // Full sweep
    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'(8'h80 + i));
    write_burst(8'h80, 256, d, -1, 0);
    read_burst(8'h80, 256, -1);

    repeat (3) tick();
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("rd_queue_empty", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
